// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl - address/twiddle sequencer for an in-place radix-2 DIT FFT
// that time-shares one butterfly across all stages. Write-back addresses
// are the read addresses delayed through a BF_LAT+1 deep pipeline.
// Optional feature macro: FFT_SEQ_BITREV_EN (adds LOAD phase, ld_valid/ld_addr).
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | counting ld_valid samples, presenting bit-reversed ld_addr
// RUN   | issuing one butterfly read per cycle
// DRAIN | waiting for the last write of the stage to retire
// DONE  | one-cycle done pulse, then back to IDLE
module fft_seq_ctrl #(
  parameter int LOG2N  = 2,
  parameter int BF_LAT = 1,
  localparam int SW    = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N)
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [SW-1:0]    stage,
`ifdef FFT_SEQ_BITREV_EN
  input  logic             ld_valid,
  output logic [LOG2N-1:0] ld_addr,
`endif
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int N  = 1 << LOG2N;
  localparam int JW = LOG2N - 1;
  localparam logic [JW-1:0] J_LAST     = JW'((N / 2) - 1);
  localparam logic [SW-1:0] S_LAST     = SW'(LOG2N - 1);
  localparam logic [2:0]    DRAIN_INIT = 3'(BF_LAT);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [JW-1:0]    j_q, j_d;
  logic [2:0]       drain_q, drain_d;
  logic [LOG2N-1:0] jx, pos;
  int unsigned      sh;
  logic [LOG2N-1:0] addr_a_d, addr_b_d;
  logic [LOG2N-2:0] tw_d;
  logic [BF_LAT:0]  pipe_v;
  logic [LOG2N-1:0] pipe_a [BF_LAT+1];
  logic [LOG2N-1:0] pipe_b [BF_LAT+1];
`ifdef FFT_SEQ_BITREV_EN
  logic [LOG2N-1:0] ld_cnt_q, ld_cnt_d, ld_rev_d;
`endif

  // Next state: butterfly index within the stage, stage number, drain timer.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    drain_d = drain_q;
`ifdef FFT_SEQ_BITREV_EN
    ld_cnt_d = ld_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          stage_d = '0;
          j_d     = '0;
`ifdef FFT_SEQ_BITREV_EN
          ld_cnt_d = '0;
          state_d  = LOAD;
`else
          state_d  = RUN;
`endif
        end
      end
`ifdef FFT_SEQ_BITREV_EN
      LOAD: begin
        if (ld_valid) begin
          ld_cnt_d = ld_cnt_q + LOG2N'(1);
          if (ld_cnt_q == LOG2N'(N - 1)) state_d = RUN;
        end
      end
`endif
      RUN: begin
        if (j_q == J_LAST) begin
          state_d = DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == 3'd0) begin
          if (stage_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + SW'(1);
            j_d     = '0;
          end
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Butterfly addresses and twiddle exponent for the index about to issue.
  always_comb begin
    sh       = 32'(stage_d);
    jx       = LOG2N'(j_d);
    pos      = jx & ((LOG2N'(1) << sh) - LOG2N'(1));
    addr_a_d = ((jx >> sh) << (sh + 1)) | pos;
    addr_b_d = addr_a_d + (LOG2N'(1) << sh);
    tw_d     = (LOG2N-1)'(pos << (LOG2N - 1 - sh));
  end

  // Control state and registered read-side outputs; reset zeroes everything.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      j_q       <= '0;
      drain_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      stage     <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      j_q       <= j_d;
      drain_q   <= drain_d;
      busy      <= (state_d == LOAD) || (state_d == RUN) || (state_d == DRAIN);
      done      <= (state_d == DONE);
      rd_en     <= (state_d == RUN);
      rd_addr_a <= (state_d == RUN) ? addr_a_d : '0;
      rd_addr_b <= (state_d == RUN) ? addr_b_d : '0;
      tw_idx    <= (state_d == RUN) ? tw_d : '0;
      stage     <= ((state_d == RUN) || (state_d == DRAIN)) ? stage_d : '0;
    end
  end

  // Write-back pipeline: the read strobe and addresses delayed BF_LAT+1 cycles.
  always_ff @(posedge clk1) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i <= BF_LAT; i++) begin
        pipe_a[i] <= '0;
        pipe_b[i] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_en;
      pipe_a[0] <= rd_addr_a;
      pipe_b[0] <= rd_addr_b;
      for (int i = 1; i <= BF_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  assign wr_en     = pipe_v[BF_LAT];
  assign wr_addr_a = pipe_a[BF_LAT];
  assign wr_addr_b = pipe_b[BF_LAT];

`ifdef FFT_SEQ_BITREV_EN
  // Bit-reverse of the sample count that the next ld_valid will load.
  always_comb begin
    ld_rev_d = '0;
    for (int i = 0; i < LOG2N; i++) ld_rev_d[i] = ld_cnt_d[LOG2N-1-i];
  end

  // Load counter and registered load address (zero outside LOAD).
  always_ff @(posedge clk1) begin
    if (rst) begin
      ld_cnt_q <= '0;
      ld_addr  <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      ld_addr  <= (state_d == LOAD) ? ld_rev_d : '0;
    end
  end
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl - directed bench for fft_seq_ctrl with two instances:
// u2 (LOG2N=2, BF_LAT=1) and u3 (LOG2N=3, BF_LAT=0).
module tb_fft_seq_ctrl;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic       rst2, start2, busy2, done2, rd_en2, wr_en2;
  logic [1:0] ra2, rb2, wa2, wb2;
  logic [0:0] tw2, st2;
  logic       rst3, start3, busy3, done3, rd_en3, wr_en3;
  logic [2:0] ra3, rb3, wa3, wb3;
  logic [1:0] tw3, st3;
`ifdef FFT_SEQ_BITREV_EN
  logic       ld2, ld3;
  logic [1:0] la2;
  logic [2:0] la3;
`endif

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_rd, n_done, cp, idx;

  // u2 expected per cycle after start (c0 = first rd_en)
  int e_rd   [10] = '{1,1,0,0,1,1,0,0,0,0};
  int e_ra   [10] = '{0,2,0,0,0,1,0,0,0,0};
  int e_rb   [10] = '{1,3,0,0,2,3,0,0,0,0};
  int e_tw   [10] = '{0,0,0,0,0,1,0,0,0,0};
  int e_st   [10] = '{0,0,0,0,1,1,0,0,0,0};
  int e_wr   [10] = '{0,0,1,1,0,0,1,1,0,0};
  int e_wa   [10] = '{0,0,0,2,0,0,0,1,0,0};
  int e_wb   [10] = '{0,0,1,3,0,0,2,3,0,0};
  int e_busy [10] = '{1,1,1,1,1,1,1,1,0,0};
  int e_done [10] = '{0,0,0,0,0,0,0,0,1,0};

  // u3 issue order: stage*4 + j
  int t3_a  [12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
  int t3_b  [12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
  int t3_tw [12] = '{0,0,0,0, 0,2,0,2, 0,1,2,3};

  fft_seq_ctrl #(.LOG2N(2), .BF_LAT(1)) u2 (
    .clk1(clk1), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr_a(ra2), .rd_addr_b(rb2), .tw_idx(tw2), .stage(st2),
`ifdef FFT_SEQ_BITREV_EN
    .ld_valid(ld2), .ld_addr(la2),
`endif
    .wr_en(wr_en2), .wr_addr_a(wa2), .wr_addr_b(wb2)
  );

  fft_seq_ctrl #(.LOG2N(3), .BF_LAT(0)) u3 (
    .clk1(clk1), .rst(rst3), .start(start3), .busy(busy3), .done(done3),
    .rd_en(rd_en3), .rd_addr_a(ra3), .rd_addr_b(rb3), .tw_idx(tw3), .stage(st3),
`ifdef FFT_SEQ_BITREV_EN
    .ld_valid(ld3), .ld_addr(la3),
`endif
    .wr_en(wr_en3), .wr_addr_a(wa3), .wr_addr_b(wb3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Start u2; returns positioned at the first RUN cycle (c0).
  task automatic go2(input bit hold);
    start2 = 1'b1;
    tick();
    if (!hold) start2 = 1'b0;
`ifdef FFT_SEQ_BITREV_EN
    ld2 = 1'b1;
    repeat (4) tick();
    ld2 = 1'b0;
`endif
  endtask

  // Start u3; with the load phase, loads 8 samples with gaps and checks ld_addr.
  task automatic go3();
`ifdef FFT_SEQ_BITREV_EN
    int lr [8] = '{0,4,2,6,1,5,3,7};
`endif
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
`ifdef FFT_SEQ_BITREV_EN
    for (int k = 0; k < 8; k++) begin
      if (k % 3 == 1) begin
        ld3 = 1'b0;
        tick();
      end
      ld3 = 1'b1;
      check($sformatf("ld_addr_%0d", k), 32'(la3), lr[k]);
      check($sformatf("ld_no_rd_%0d", k), 32'(rd_en3), 0);
      tick();
      ld3 = 1'b0;
    end
    check("ld_run_begins", 32'(rd_en3), 1);
    check("ld_addr_idle", 32'(la3), 0);
`endif
  endtask

  initial begin
    rst2 = 1'b1; start2 = 1'b0; rst3 = 1'b1; start3 = 1'b0;
`ifdef FFT_SEQ_BITREV_EN
    ld2 = 1'b0; ld3 = 1'b0;
`endif
    tick(); tick();
    rst2 = 1'b0; rst3 = 1'b0;
    tick();

    // reset state
    check("rst_busy",  32'(busy2),  0);
    check("rst_done",  32'(done2),  0);
    check("rst_rd_en", 32'(rd_en2), 0);
    check("rst_wr_en", 32'(wr_en2), 0);
    check("rst_ra",    32'(ra2),    0);
    check("rst_rb",    32'(rb2),    0);
    check("rst_tw",    32'(tw2),    0);
    check("rst_stage", 32'(st2),    0);
    check("rst_wa",    32'(wa2),    0);
    check("rst_wb",    32'(wb2),    0);
    check("rst3_busy", 32'(busy3),  0);

    // N=4, BF_LAT=1 full sequence
    go2(1'b0);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("t1_rd_c%0d", c),   32'(rd_en2), e_rd[c]);
      check($sformatf("t1_wr_c%0d", c),   32'(wr_en2), e_wr[c]);
      check($sformatf("t1_busy_c%0d", c), 32'(busy2),  e_busy[c]);
      check($sformatf("t1_done_c%0d", c), 32'(done2),  e_done[c]);
      if (e_rd[c] != 0) begin
        check($sformatf("t1_ra_c%0d", c), 32'(ra2), e_ra[c]);
        check($sformatf("t1_rb_c%0d", c), 32'(rb2), e_rb[c]);
        check($sformatf("t1_tw_c%0d", c), 32'(tw2), e_tw[c]);
        check($sformatf("t1_st_c%0d", c), 32'(st2), e_st[c]);
      end
      if (e_wr[c] != 0) begin
        check($sformatf("t1_wa_c%0d", c), 32'(wa2), e_wa[c]);
        check($sformatf("t1_wb_c%0d", c), 32'(wb2), e_wb[c]);
      end
      tick();
    end

    // N=8, BF_LAT=0: 3 stages x (4 issue + 1 drain), done at cycle 15
    go3();
    for (int c = 0; c < 16; c++) begin
      if (c < 15 && (c % 5) < 4) begin
        idx = (c / 5) * 4 + (c % 5);
        check($sformatf("t2_rd_c%0d", c), 32'(rd_en3), 1);
        check($sformatf("t2_ra_c%0d", c), 32'(ra3), t3_a[idx]);
        check($sformatf("t2_rb_c%0d", c), 32'(rb3), t3_b[idx]);
        check($sformatf("t2_tw_c%0d", c), 32'(tw3), t3_tw[idx]);
        check($sformatf("t2_st_c%0d", c), 32'(st3), c / 5);
      end else begin
        check($sformatf("t2_rd_c%0d", c), 32'(rd_en3), 0);
      end
      cp = c - 1;
      if (c >= 1 && (cp % 5) < 4) begin
        idx = (cp / 5) * 4 + (cp % 5);
        check($sformatf("t2_wr_c%0d", c), 32'(wr_en3), 1);
        check($sformatf("t2_wa_c%0d", c), 32'(wa3), t3_a[idx]);
        check($sformatf("t2_wb_c%0d", c), 32'(wb3), t3_b[idx]);
      end else begin
        check($sformatf("t2_wr_c%0d", c), 32'(wr_en3), 0);
      end
      check($sformatf("t2_done_c%0d", c), 32'(done3), (c == 15) ? 1 : 0);
      tick();
    end

    // start held high through a whole run
    go2(1'b1);
    n_rd = 0; n_done = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 9) start2 = 1'b0;
      n_rd   += int'(rd_en2);
      n_done += int'(done2);
      tick();
    end
    check("held_rd_count",   n_rd,   4);
    check("held_done_count", n_done, 1);
    check("held_idle_busy",  32'(busy2), 0);

    // start re-pulsed while busy
    go2(1'b0);
    n_rd = 0; n_done = 0;
    for (int c = 0; c < 15; c++) begin
      start2 = (c == 3 || c == 5);
      n_rd   += int'(rd_en2);
      n_done += int'(done2);
      tick();
    end
    start2 = 1'b0;
    check("repulse_rd_count",   n_rd,   4);
    check("repulse_done_count", n_done, 1);
    tick();
    check("repulse_idle_busy",  32'(busy2), 0);
    check("repulse_idle_rd",    32'(rd_en2), 0);

    // reset mid-RUN with a write pending
    go2(1'b0);
    tick();
    check("midrst_pre_rd", 32'(rd_en2), 1);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    check("midrst_wr",    32'(wr_en2), 0);
    check("midrst_rd",    32'(rd_en2), 0);
    check("midrst_busy",  32'(busy2),  0);
    check("midrst_ra",    32'(ra2),    0);
    check("midrst_rb",    32'(rb2),    0);
    check("midrst_wa",    32'(wa2),    0);
    check("midrst_wb",    32'(wb2),    0);
    check("midrst_stage", 32'(st2),    0);
    tick();
    check("midrst_wr_after1", 32'(wr_en2), 0);
    tick();
    check("midrst_wr_after2", 32'(wr_en2), 0);
    check("midrst_busy_after", 32'(busy2), 0);
    go2(1'b0);
    check("restart_rd",    32'(rd_en2), 1);
    check("restart_stage", 32'(st2),    0);
    check("restart_ra",    32'(ra2),    0);
    check("restart_rb",    32'(rb2),    1);
    check("restart_busy",  32'(busy2),  1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
